mem_access_unit: RTL and testbench

- M-stage data-access sequencer. Sits between the EX_MEM register and the MEM_WB register.
- Turns one decoded load/store into a req/ack transaction on the data bus (DM, timers, interrupt generator).
- Stalls the pipeline while the transaction is in flight. Returns the extended load result as DMout for MEM_WB.
- Reports address exceptions (AdEL/AdES) to CP0.

---
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : M-stage load/store sequencer with req/ack data bus.
// Optional: MEM_TIMEOUT_EN enables a wait-state timeout raising AdEL/AdES.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter logic [31:0] DM_TOP         = 32'h0000_2FFF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        valid_in,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] DMout,
  output logic        busy,
  output logic        done,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] c_ADEL = 5'd4;
  localparam logic [4:0] c_ADES = 5'd5;

  state_t      r_state;
  logic        r_is_store;
  logic [1:0]  r_size;
  logic        r_sign_ext;
  logic [1:0]  r_lo;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_byteen;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_dmout;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic        w_in_map;
  logic        w_in_io;
  logic        w_fault;
  logic        w_start;
  logic        w_tmo_hit;
  logic        w_tmo_exc;
  logic [3:0]  w_byteen;
  logic [31:0] w_wdata;
  logic [31:0] w_rshift;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load;

  assign w_is_byte    = (size == 2'b00);
  assign w_is_half    = (size == 2'b01);
  assign w_is_word    = size[1];
  assign w_misaligned = (w_is_half && addr[0]) || (w_is_word && (addr[1:0] != 2'b00));
  assign w_in_io      = (addr >= 32'h7F00) && (addr <= 32'h7F23);
  assign w_in_map     = (addr <= DM_TOP)
                     || ((addr >= 32'h7F00) && (addr <= 32'h7F0B))
                     || ((addr >= 32'h7F10) && (addr <= 32'h7F1B))
                     || ((addr >= 32'h7F20) && (addr <= 32'h7F23));
  // Timer count registers are read-only from software.
  assign w_fault      = w_misaligned || !w_in_map || (w_in_io && !w_is_word)
                     || (is_store && ((addr == 32'h7F08) || (addr == 32'h7F18)));

  assign w_start = (r_state == S_IDLE) && valid_in && !w_fault && !Req;

  always_comb begin
    w_byteen = 4'b0000;
    w_wdata  = 32'h0;
    if (is_store) begin
      if (w_is_byte) begin
        w_byteen = 4'b0001 << addr[1:0];
        w_wdata  = {4{wdata[7:0]}};
      end else if (w_is_half) begin
        w_byteen = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata  = {2{wdata[15:0]}};
      end else begin
        w_byteen = 4'b1111;
        w_wdata  = wdata;
      end
    end
  end

  assign w_rshift = bus_rdata >> {r_lo, 3'b000};
  assign w_lane_b = w_rshift[7:0];
  assign w_lane_h = r_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_load = bus_rdata;
    if (r_size == 2'b00)
      w_load = {{24{r_sign_ext & w_lane_b[7]}}, w_lane_b};
    else if (r_size == 2'b01)
      w_load = {{16{r_sign_ext & w_lane_h[15]}}, w_lane_h};
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_tmo_exc;

  assign w_tmo_hit = (r_state == S_WAIT) && !bus_ack
                  && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_tmo_exc = r_tmo_exc;

  always_ff @(posedge clk) begin
    if (reset || Req) begin
      r_tmo_cnt <= '0;
      r_tmo_exc <= 1'b0;
    end else if (w_start) begin
      r_tmo_cnt <= '0;
      r_tmo_exc <= 1'b0;
    end else if (r_state == S_WAIT && !bus_ack) begin
      if (w_tmo_hit)
        r_tmo_exc <= 1'b1;
      else
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else if (r_state == S_DONE) begin
      r_tmo_exc <= 1'b0;
    end
  end
`else
  // No timeout: WAIT lasts until ack or flush.
  assign w_tmo_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign w_tmo_exc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_size       <= 2'b00;
      r_sign_ext   <= 1'b0;
      r_lo         <= 2'b00;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= 32'h0;
      r_bus_byteen <= 4'b0000;
      r_bus_wdata  <= 32'h0;
      r_dmout      <= 32'h0;
    end else if (Req) begin
      // Flush: abandon any access; an unacked store never commits.
      r_state   <= S_IDLE;
      r_bus_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state      <= S_WAIT;
            r_is_store   <= is_store;
            r_size       <= size;
            r_sign_ext   <= sign_ext;
            r_lo         <= addr[1:0];
            r_bus_req    <= 1'b1;
            r_bus_we     <= is_store;
            r_bus_addr   <= {addr[31:2], 2'b00};
            r_bus_byteen <= w_byteen;
            r_bus_wdata  <= w_wdata;
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            if (!r_is_store)
              r_dmout <= w_load;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_tmo_hit) begin
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_byteen = r_bus_byteen;
  assign bus_wdata  = r_bus_wdata;
  assign DMout      = r_dmout;
  assign busy       = w_start || (r_state == S_WAIT);
  assign done       = (r_state == S_DONE);

  always_comb begin
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    if (r_state == S_IDLE && valid_in && w_fault) begin
      exc_valid = 1'b1;
      exc_code  = is_store ? c_ADES : c_ADEL;
    end else if (r_state == S_DONE && w_tmo_exc) begin
      exc_valid = 1'b1;
      exc_code  = r_is_store ? c_ADES : c_ADEL;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : directed self-checking bench for mem_access_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        valid_in;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] DMout;
  logic        busy;
  logic        done;
  logic        exc_valid;
  logic [4:0]  exc_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Req        (Req),
    .valid_in   (valid_in),
    .is_store   (is_store),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr       (addr),
    .wdata      (wdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_byteen (bus_byteen),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .DMout      (DMout),
    .busy       (busy),
    .done       (done),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One load with ack on the first WAIT cycle; drive at negedge, sample there too.
  task automatic load_access(input string tag, input logic [31:0] a, input logic [1:0] sz,
                             input logic sx, input logic [31:0] rd, input logic [31:0] exp);
    valid_in = 1'b1; is_store = 1'b0; size = sz; sign_ext = sx; addr = a;
    #1;
    chk({tag, " idle busy"}, {31'b0, busy}, 32'd1);
    chk({tag, " idle req"}, {31'b0, bus_req}, 32'd0);
    @(negedge clk);
    chk({tag, " wait req"}, {31'b0, bus_req}, 32'd1);
    chk({tag, " wait busy"}, {31'b0, busy}, 32'd1);
    chk({tag, " wait addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, " wait byteen"}, {28'b0, bus_byteen}, 32'd0);
    bus_ack = 1'b1; bus_rdata = rd;
    @(negedge clk);
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " done req"}, {31'b0, bus_req}, 32'd0);
    chk({tag, " done busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " DMout"}, DMout, exp);
    bus_ack = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk({tag, " done drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; valid_in = 1'b0; is_store = 1'b0; size = 2'b10;
    sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst DMout", DMout, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst exc", {26'b0, exc_valid, exc_code}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    load_access("lw 10", 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_access("lb 13", 32'h13, 2'b00, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80);
    load_access("lhu 12", 32'h12, 2'b01, 1'b0, 32'h80FF_0000, 32'h0000_80FF);
    load_access("lbu 11", 32'h11, 2'b00, 1'b0, 32'h1234_A5CD, 32'h0000_00A5);
    load_access("lh 10", 32'h10, 2'b01, 1'b1, 32'h1234_9876, 32'hFFFF_9876);
    load_access("lw 7F20", 32'h7F20, 2'b10, 1'b0, 32'h0000_0042, 32'h0000_0042);
    load_access("lb 2FFF", 32'h2FFF, 2'b00, 1'b0, 32'h7700_0000, 32'h0000_0077);

    // Half store, upper lane
    valid_in = 1'b1; is_store = 1'b1; size = 2'b01; addr = 32'h06; wdata = 32'h1234_ABCD;
    @(negedge clk);
    chk("sh addr", bus_addr, 32'h04);
    chk("sh byteen", {28'b0, bus_byteen}, 32'hC);
    chk("sh wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh we", {31'b0, bus_we}, 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("sh done", {31'b0, done}, 32'd1);
    chk("sh DMout kept", DMout, 32'h0000_0077);
    bus_ack = 1'b0; valid_in = 1'b0;
    @(negedge clk);

    // Byte store, lane 3
    valid_in = 1'b1; is_store = 1'b1; size = 2'b00; addr = 32'h13; wdata = 32'hFFFF_FF5A;
    @(negedge clk);
    chk("sb byteen", {28'b0, bus_byteen}, 32'h8);
    chk("sb wdata", bus_wdata, 32'h5A5A_5A5A);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; valid_in = 1'b0;
    @(negedge clk);

    // Address exceptions: stay IDLE, no request
    valid_in = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h2;
    #1;
    chk("lw 2 exc", {26'b0, exc_valid, exc_code}, {26'b0, 1'b1, 5'd4});
    chk("lw 2 busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("lw 2 no req", {31'b0, bus_req}, 32'd0);
    is_store = 1'b1; addr = 32'h7F08;
    #1 chk("sw 7F08 exc", {26'b0, exc_valid, exc_code}, {26'b0, 1'b1, 5'd5});
    size = 2'b00; addr = 32'h7F00;
    #1 chk("sb 7F00 exc", {26'b0, exc_valid, exc_code}, {26'b0, 1'b1, 5'd5});
    is_store = 1'b0; size = 2'b10; addr = 32'h3000;
    #1 chk("lw 3000 exc", {26'b0, exc_valid, exc_code}, {26'b0, 1'b1, 5'd4});
    addr = 32'h7F0C;
    #1 chk("lw 7F0C exc", {26'b0, exc_valid, exc_code}, {26'b0, 1'b1, 5'd4});
    addr = 32'h7F08;
    #1 chk("lw 7F08 ok", {26'b0, exc_valid, exc_code}, 32'd0);
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Flush in the second WAIT cycle, late ack ignored
    valid_in = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h20;
    @(negedge clk);
    chk("flush wait1 req", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    chk("flush wait2 req", {31'b0, bus_req}, 32'd1);
    Req = 1'b1;
    @(negedge clk);
    chk("flush req low", {31'b0, bus_req}, 32'd0);
    Req = 1'b0; valid_in = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    #1 chk("flush idle busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("flush no done", {31'b0, done}, 32'd0);
    chk("flush DMout", DMout, 32'h0000_0077);
    bus_ack = 1'b0;
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    valid_in = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h0;
    @(negedge clk);
    for (int i = 1; i < 16; i++) @(negedge clk);
    chk("tmo wait16 req", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    chk("tmo req drop", {31'b0, bus_req}, 32'd0);
    chk("tmo done", {31'b0, done}, 32'd1);
    chk("tmo exc", {26'b0, exc_valid, exc_code}, {26'b0, 1'b1, 5'd5});
    valid_in = 1'b0;
    @(negedge clk);
`else
    valid_in = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("no tmo req held", {31'b0, bus_req}, 32'd1);
    chk("no tmo busy", {31'b0, busy}, 32'd1);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; valid_in = 1'b0;
    @(negedge clk);
`endif

    // Reset in the middle of WAIT
    valid_in = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h44;
    @(negedge clk);
    chk("rstw req", {31'b0, bus_req}, 32'd1);
    reset = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    chk("rstw req low", {31'b0, bus_req}, 32'd0);
    chk("rstw addr", bus_addr, 32'h0);
    chk("rstw DMout", DMout, 32'h0);
    chk("rstw busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
